// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the iterative div/divu sequencer.
package div_sequencer_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REM_W  = 33;

   localparam logic [DATA_W-1:0] DIV0_QUO = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PREP  = 3'd1,
      ST_ITER  = 3'd2,
      ST_FIXUP = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
   } div_result_t;

   // Two's-complement magnitude; 0x80000000 maps to itself as an unsigned value.
   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                   input logic is_signed);
      return (is_signed && v[DATA_W-1]) ? DATA_W'(-v) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on {rem, quo}.
module div_step
   import div_sequencer_pkg::*;
(
   input  logic [REM_W-1:0]  rem_in,
   input  logic [DATA_W-1:0] quo_in,
   input  logic [DATA_W-1:0] divisor,
   output logic [REM_W-1:0]  rem_out,
   output logic [DATA_W-1:0] quo_out
);

   localparam int unsigned SHIFT_W = REM_W + 1;

   logic [SHIFT_W-1:0] shifted;
   logic [REM_W-1:0]   trial;
   logic               restore;

   always_comb begin
      shifted = {rem_in, quo_in[DATA_W-1]};
      trial   = shifted[REM_W-1:0] - REM_W'(divisor);
      restore = shifted < SHIFT_W'(divisor);
      rem_out = restore ? shifted[REM_W-1:0] : trial;
      quo_out = {quo_in[DATA_W-2:0], ~restore};
   end

endmodule

// File: rtl/div_sequencer.sv
// Execute-stage multi-cycle div/divu sequencer: stalls the front end, runs a
// fixed-latency restoring divide and pulses the HI/LO result for one cycle.
module div_sequencer
   import div_sequencer_pkg::*;
#(
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start_e,
   input  logic        is_signed_e,
   input  logic [31:0] dividend_e,
   input  logic [31:0] divisor_e,
   input  logic        flush,
   output logic        stall_e,
   output logic        busy,
   output logic        has_div_e,
   output logic [31:0] div_hi_e,
   output logic [31:0] div_lo_e
);

   localparam int unsigned N_ITER = DATA_W / BITS_PER_CYCLE;
   localparam int unsigned CNT_W  = $clog2(N_ITER + 1);

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  dividend_q;
   logic [DATA_W-1:0]  divisor_q;
   logic [DATA_W-1:0]  quo_q;
   logic [REM_W-1:0]   rem_q;
   logic               signed_q;
   logic               q_neg_q;
   logic               r_neg_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               has_div_q;
   div_result_t        result_q;
   div_result_t        fix;

   logic [REM_W-1:0]   rem_chain [BITS_PER_CYCLE+1];
   logic [DATA_W-1:0]  quo_chain [BITS_PER_CYCLE+1];

   assign rem_chain[0] = rem_q;
   assign quo_chain[0] = quo_q;

   for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
      div_step u_step (
         .rem_in  (rem_chain[i]),
         .quo_in  (quo_chain[i]),
         .divisor (divisor_q),
         .rem_out (rem_chain[i+1]),
         .quo_out (quo_chain[i+1])
      );
   end

   // Next state and the combinational stall to the hazard unit.
   always_comb begin
      state_d = state_q;
      stall_e = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_e) begin
               state_d = ST_PREP;
               stall_e = 1'b1;
            end
         end
         ST_PREP: begin
            state_d = ST_ITER;
            stall_e = 1'b1;
         end
         ST_ITER: begin
            stall_e = 1'b1;
            if (cnt_q == CNT_W'(N_ITER - 1)) state_d = ST_FIXUP;
         end
         ST_FIXUP: begin
            stall_e = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d = ST_IDLE;
         stall_e = 1'b0;
      end
   end

   // Sign correction; divide-by-zero overrides the sign rules.
   always_comb begin
      fix.lo = q_neg_q ? DATA_W'(-quo_q) : quo_q;
      fix.hi = r_neg_q ? DATA_W'(-rem_q[DATA_W-1:0]) : rem_q[DATA_W-1:0];
      if (divisor_q == '0) begin
         fix.lo = DIV0_QUO;
         fix.hi = dividend_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         dividend_q <= '0;
         divisor_q  <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         signed_q   <= 1'b0;
         q_neg_q    <= 1'b0;
         r_neg_q    <= 1'b0;
         cnt_q      <= '0;
         has_div_q  <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q   <= state_d;
         has_div_q <= (state_q == ST_FIXUP) && !flush;
         case (state_q)
            ST_IDLE: begin
               if (start_e && !flush) begin
                  dividend_q <= dividend_e;
                  divisor_q  <= divisor_e;
                  signed_q   <= is_signed_e;
               end
            end
            ST_PREP: begin
               quo_q     <= magnitude(dividend_q, signed_q);
               divisor_q <= magnitude(divisor_q, signed_q);
               q_neg_q   <= signed_q & (dividend_q[DATA_W-1] ^ divisor_q[DATA_W-1]);
               r_neg_q   <= signed_q & dividend_q[DATA_W-1];
               rem_q     <= '0;
               cnt_q     <= '0;
            end
            ST_ITER: begin
               rem_q <= rem_chain[BITS_PER_CYCLE];
               quo_q <= quo_chain[BITS_PER_CYCLE];
               cnt_q <= cnt_q + CNT_W'(1);
            end
            ST_FIXUP: begin
               if (!flush) result_q <= fix;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign has_div_e = has_div_q;
   assign div_hi_e  = result_q.hi;
   assign div_lo_e  = result_q.lo;

endmodule
